mult_seq_ctrl: RTL and testbench

Sequencing front-end for the 8x8 Booth sequential multiplier. It accepts operand pairs on a valid/ready stream and pulses the multiplier's `start`. It then waits out the iterative computation, captures the 16-bit product on the first cycle the multiplier reports not-busy, and returns it with its tag through a 2-entry output buffer with valid/ready. It sits directly upstream of the multiplier and owns its `start`, `mc` and `mp` inputs exclusively.

---
 rtl/mult_seq_ctrl.sv | 156 +++++++++++++++
 tb/tb_mult_seq_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: sequencing front-end for the 8x8 Booth
// sequential multiplier, with a 2-entry result buffer.
module mult_seq_ctrl #(
  parameter int TAG_W    = 4,
  parameter int WAIT_MAX = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_mc,
  input  logic [7:0]       in_mp,
  input  logic [TAG_W-1:0] in_tag,
  output logic             mult_start,
  output logic [7:0]       mult_mc,
  output logic [7:0]       mult_mp,
  input  logic             mult_busy,
  input  logic [15:0]      mult_prd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_prd,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  localparam int CW = $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] WLIM = CW'(WAIT_MAX);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] CAPT  = 2'd3;

  typedef struct packed {
    logic [15:0]      prd;
    logic [TAG_W-1:0] tag;
    logic             err;
  } res_t;

  logic [1:0]       state;
  logic [1:0]       state_nx;
  logic [CW-1:0]    wcnt;
  logic [7:0]       mc_q;
  logic [7:0]       mp_q;
  logic [TAG_W-1:0] tag_q;
  res_t             ent0;
  res_t             ent1;
  res_t             push_d;
  logic [1:0]       cnt;
  logic             accept;
  logic             done_ok;
  logic             tmo;
  logic             push;
  logic             pop;

  assign in_ready   = (state == IDLE) &&
                      (cnt != 2'd2);
  assign accept     = in_valid && in_ready;
  assign mult_start = (state == START);
  assign mult_mc    = mc_q;
  assign mult_mp    = mp_q;

  // first WAIT cycle (wcnt == 0) ignores a stale busy
  assign done_ok = (state == WAIT) &&
                   (wcnt != '0) && !mult_busy;
  assign tmo     = (state == WAIT) && !done_ok &&
                   (wcnt == WLIM);
  assign push    = done_ok || tmo;
  assign pop     = out_valid && out_ready;

  assign push_d = {done_ok ? mult_prd : 16'h0,
                   tag_q, tmo};

  assign out_valid = (cnt != 2'd0);
  assign out_prd   = ent0.prd;
  assign out_tag   = ent0.tag;
  assign out_err   = ent0.err;

  // next-state decode
  always_comb begin
    state_nx = state;
    unique case (1'b1)
      state == IDLE:
        if (accept) state_nx = START;
      state == START:
        state_nx = WAIT;
      state == WAIT:
        if (done_ok)  state_nx = CAPT;
        else if (tmo) state_nx = IDLE;
      state == CAPT:
        state_nx = IDLE;
      default:
        state_nx = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // wait counter: cleared in START, counts WAIT cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      wcnt <= '0;
    else if (state == START)
      wcnt <= '0;
    else if (state == WAIT && wcnt != WLIM)
      wcnt <= wcnt + CW'(1);
  end

  // operand registers, loaded on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mc_q  <= '0;
      mp_q  <= '0;
      tag_q <= '0;
    end else if (accept) begin
      mc_q  <= in_mc;
      mp_q  <= in_mp;
      tag_q <= in_tag;
    end
  end

  // 2-entry result buffer, ent0 is the head
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0 <= '0;
      ent1 <= '0;
      cnt  <= 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) ent0 <= push_d;
          else             ent1 <= push_d;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          ent0 <= ent1;
          cnt  <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            ent0 <= push_d;
          end else begin
            ent0 <= ent1;
            ent1 <= push_d;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// tb_mult_seq_ctrl: directed + random bench with a
// behavioural Booth multiplier stand-in and scoreboard.
module tb_mult_seq_ctrl;

  localparam int TAG_W    = 4;
  localparam int WAIT_MAX = 15;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_mc;
  logic [7:0]       in_mp;
  logic [TAG_W-1:0] in_tag;
  logic             mult_start;
  logic [7:0]       mult_mc;
  logic [7:0]       mult_mp;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_prd;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;

  // multiplier stand-in controls
  logic        hang    = 1'b0;
  logic        stale   = 1'b0;
  logic        use_ovr = 1'b0;
  logic [15:0] ovr     = 16'h0;
  int          s_cnt   = 0;
  logic        s_busy  = 1'b0;
  logic [15:0] s_prd   = 16'h0;
  logic [15:0] s_res   = 16'h0;

  logic rnd_rdy = 1'b0;
  int   n_chk   = 0;
  int   n_pass  = 0;
  int   rd_i    = 0;

  logic [20:0] got_q[$];
  logic [20:0] exp_q[$];

  mult_seq_ctrl #(
    .TAG_W(TAG_W),
    .WAIT_MAX(WAIT_MAX)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_mc(in_mc),
    .in_mp(in_mp),
    .in_tag(in_tag),
    .mult_start(mult_start),
    .mult_mc(mult_mc),
    .mult_mp(mult_mp),
    .mult_busy(s_busy),
    .mult_prd(s_prd),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_prd(out_prd),
    .out_tag(out_tag),
    .out_err(out_err)
  );

  always #5 clk = ~clk;

  // signed 8x8 product, what {A,Q} holds when done
  function automatic logic [15:0] bprod(
    input logic [7:0] a, input logic [7:0] b);
    logic signed [15:0] sa;
    logic signed [15:0] sb;
    logic signed [15:0] p;
    sa = {{8{a[7]}}, a};
    sb = {{8{b[7]}}, b};
    p  = sa * sb;
    return p;
  endfunction

  // multiplier stand-in: busy 8 cycles after start,
  // product valid only in the first not-busy cycle
  always @(posedge clk) begin
    if (mult_start) begin
      s_cnt  <= 8;
      s_busy <= !stale;
      s_prd  <= 16'hDEAD;
      s_res  <= use_ovr ? ovr
                        : bprod(mult_mc, mult_mp);
    end else if (s_cnt != 0) begin
      s_cnt  <= s_cnt - 1;
      s_busy <= (s_cnt == 1) ? hang : 1'b1;
      if (s_cnt == 1) s_prd <= s_res;
    end else begin
      s_busy <= hang;
      s_prd  <= 16'hFFFF;
    end
  end

  // record every popped result
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready)
      got_q.push_back({out_prd, out_tag, out_err});
  end

  task automatic chk(input string tg,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h",
                  tg, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_rdy)
      out_ready = 1'($urandom_range(0, 1));
  endtask

  // returns at accept edge + 1
  task automatic send(input logic [7:0] mc,
                      input logic [7:0] mp,
                      input logic [3:0] tg);
    int ok = 0;
    in_mc    = mc;
    in_mp    = mp;
    in_tag   = tg;
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (in_ready) begin
        ok = 1;
        tick();
        break;
      end
      tick();
    end
    in_valid = 1'b0;
    chk("accept", 32'(ok), 32'd1);
  endtask

  task automatic wait_valid(input int from,
                            output int lat);
    lat = from;
    while (!out_valid && lat < 60) begin
      tick();
      lat++;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (got_q.size() < exp_q.size() && n < 500) begin
      tick();
      n++;
    end
    chk("res_count", 32'(got_q.size()),
        32'(exp_q.size()));
    for (int i = rd_i; i < exp_q.size(); i++)
      chk("res", (i < got_q.size()) ? 32'(got_q[i]) : 32'h0,
          32'(exp_q[i]));
    rd_i = exp_q.size();
  endtask

  task automatic chk_reset_outs(input string tg);
    chk({tg, "_in_ready"},  32'(in_ready),   32'd1);
    chk({tg, "_start"},     32'(mult_start), 32'd0);
    chk({tg, "_mc"},        32'(mult_mc),    32'd0);
    chk({tg, "_mp"},        32'(mult_mp),    32'd0);
    chk({tg, "_out_valid"}, 32'(out_valid),  32'd0);
    chk({tg, "_out_prd"},   32'(out_prd),    32'd0);
    chk({tg, "_out_tag"},   32'(out_tag),    32'd0);
    chk({tg, "_out_err"},   32'(out_err),    32'd0);
  endtask

  initial begin
    int lat;
    int c;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] t;
    in_valid  = 1'b0;
    in_mc     = '0;
    in_mp     = '0;
    in_tag    = '0;
    out_ready = 1'b0;
    rst_n     = 1'b0;

    #12;
    chk_reset_outs("rst");
    tick();
    rst_n = 1'b1;
    tick();

    // single op with fixed stub product
    out_ready = 1'b1;
    use_ovr   = 1'b1;
    ovr       = 16'h000F;
    send(8'd3, 8'd5, 4'd2);
    chk("start_hi", 32'(mult_start), 32'd1);
    chk("start_mc", 32'(mult_mc), 32'd3);
    chk("start_mp", 32'(mult_mp), 32'd5);
    tick();
    chk("start_1cyc", 32'(mult_start), 32'd0);
    wait_valid(1, lat);
    chk("lat_single", 32'(lat), 32'd10);
    chk("single_prd", 32'(out_prd), 32'h000F);
    chk("single_tag", 32'(out_tag), 32'd2);
    chk("single_err", 32'(out_err), 32'd0);
    chk("capt_ready", 32'(in_ready), 32'd0);
    tick();
    chk("e11_ready", 32'(in_ready), 32'd1);
    exp_q.push_back({16'h000F, 4'd2, 1'b0});
    drain();

    // product sampled only in first not-busy cycle
    ovr = 16'h1234;
    send(8'h12, 8'h34, 4'd3);
    wait_valid(0, lat);
    chk("lat_sample", 32'(lat), 32'd10);
    chk("sample_prd", 32'(out_prd), 32'h1234);
    exp_q.push_back({16'h1234, 4'd3, 1'b0});
    drain();

    // busy low in first WAIT cycle must be ignored
    use_ovr = 1'b0;
    stale   = 1'b1;
    send(8'hF0, 8'd7, 4'd6);
    wait_valid(0, lat);
    chk("lat_stale", 32'(lat), 32'd10);
    stale = 1'b0;
    exp_q.push_back({bprod(8'hF0, 8'd7), 4'd6, 1'b0});
    drain();

    // output stall: two buffered, third held off
    out_ready = 1'b0;
    send(8'd10, 8'd11, 4'd1);
    wait_valid(0, lat);
    chk("lat_stall1", 32'(lat), 32'd10);
    send(8'd12, 8'd13, 4'd2);
    for (int i = 0; i < 12; i++) tick();
    in_mc    = 8'd14;
    in_mp    = 8'd15;
    in_tag   = 4'd3;
    in_valid = 1'b1;
    c = 0;
    for (int i = 0; i < 20; i++) begin
      if (in_ready || mult_start) c++;
      tick();
    end
    chk("stall_held", 32'(c), 32'd0);
    chk("stall_valid", 32'(out_valid), 32'd1);
    chk("stall_head", 32'(out_tag), 32'd1);
    out_ready = 1'b1;
    send(8'd14, 8'd15, 4'd3);
    exp_q.push_back({bprod(8'd10, 8'd11), 4'd1, 1'b0});
    exp_q.push_back({bprod(8'd12, 8'd13), 4'd2, 1'b0});
    exp_q.push_back({bprod(8'd14, 8'd15), 4'd3, 1'b0});
    drain();

    // timeout: START edge, then WAIT_MAX+1 WAIT cycles
    hang = 1'b1;
    send(8'd5, 8'd6, 4'd9);
    wait_valid(0, lat);
    chk("lat_tmo", 32'(lat), 32'(WAIT_MAX + 2));
    chk("tmo_err", 32'(out_err), 32'd1);
    chk("tmo_prd", 32'(out_prd), 32'd0);
    chk("tmo_tag", 32'(out_tag), 32'd9);
    exp_q.push_back({16'h0, 4'd9, 1'b1});
    hang = 1'b0;
    drain();
    send(8'd7, 8'd9, 4'd10);
    wait_valid(0, lat);
    chk("lat_post_tmo", 32'(lat), 32'd10);
    exp_q.push_back({bprod(8'd7, 8'd9), 4'd10, 1'b0});
    drain();

    // reset during START drops start at once
    send(8'd1, 8'd2, 4'd4);
    chk("rst_start_pre", 32'(mult_start), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_start_async", 32'(mult_start), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // reset on the 4th WAIT cycle
    send(8'd3, 8'd4, 4'd5);
    for (int i = 0; i < 4; i++) tick();
    rst_n = 1'b0;
    #1;
    chk_reset_outs("rstw");
    tick();
    rst_n = 1'b1;
    c = 0;
    for (int i = 0; i < 25; i++) begin
      if (out_valid) c++;
      tick();
    end
    chk("rstw_no_result", 32'(c), 32'd0);
    send(8'd3, 8'd5, 4'd7);
    wait_valid(0, lat);
    chk("lat_after_rst", 32'(lat), 32'd10);
    chk("int_prd", 32'(out_prd), 32'd15);
    chk("int_tag", 32'(out_tag), 32'd7);
    chk("int_err", 32'(out_err), 32'd0);
    exp_q.push_back({16'd15, 4'd7, 1'b0});
    drain();

    // random ops with random downstream stalls
    rnd_rdy = 1'b1;
    for (int k = 0; k < 30; k++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      t = 4'($urandom);
      send(a, b, t);
      exp_q.push_back({bprod(a, b), t, 1'b0});
    end
    drain();
    rnd_rdy   = 1'b0;
    out_ready = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
